alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Registered result stage directly downstream of the 16-bit carry-lookahead adder in the Execute path. It takes the raw adder sum and overflow indicators, applies WISC saturating arithmetic, and buffers results in a 2-entry valid/ready FIFO toward the EX/MEM boundary. It owns the architectural Z/V/N flag register, updated only when a result commits downstream.

## Interface
Parameters:
- DEPTH, 2, buffer entries; fixed at 2, no other value supported
- TAG_W, 4, destination register tag width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept (registered, = count < 2)
- in_sum  in  16  raw adder/ALU result
- in_pos_ovfl  in  1  adder positive overflow
- in_neg_ovfl  in  1  adder negative overflow
- in_arith  in  1  ADD/SUB result: saturate, update Z/V/N on commit
- in_zupd  in  1  logic/shift result: update Z only on commit
- in_dst  in  TAG_W  destination register tag
- flush  in  1  synchronous discard of all buffered entries
- out_valid  out  1  head entry valid (= count != 0)
- out_ready  in  1  downstream accepts
- out_result  out  16  head result (saturated where applicable)
- out_dst  out  TAG_W  head tag
- flag_z, flag_v, flag_n  out  1 each  architectural flags

## Operation
- Accept: in_valid & in_ready & ~flush writes entry at tail.
- Saturation at accept, only when in_arith=1: in_pos_ovfl → 0x7FFF; in_neg_ovfl → 0x8000; else in_sum. in_arith=0 → in_sum unchanged, overflow inputs ignored. Both overflow bits set is illegal; in_pos_ovfl wins.
- Stored per entry: result[15:0], dst, arith, zupd, ovfl (= in_arith & (pos|neg)).
- Commit: out_valid & out_ready & ~flush pops head.
- Flag update on commit only:
  - arith=1: Z = (result==0), N = result[15], V = ovfl (of the saturated result).
  - arith=0, zupd=1: Z = (result==0); V, N hold.
  - neither: all flags hold.
  - arith and zupd both set: treated as arith.
- FIFO: circular, 1-bit read/write pointers, 2-bit count. Simultaneous accept and commit: count unchanged, both pointers advance. At count=2, in_ready=0, so no accept even if committing that cycle.
- Flush: next cycle count=0, pointers reset to 0, flags unchanged; in-cycle accept and commit suppressed.
- out_result/out_dst driven from head entry; contents undefined-but-stable when out_valid=0 (bench must not check).

## Timing
- Reset (async assert, sync release): count=0, pointers=0, out_valid=0, in_ready=1, out_result=0, out_dst=0, flag_z=0, flag_v=0, flag_n=0, all entries cleared.
- Latency: accept at edge N → out_valid=1 after edge N; earliest commit at edge N+1. No combinational in→out bypass.
- in_ready and out_valid depend only on registered count (no dependence on out_ready/in_valid).
- Flags change at the commit edge; visible the following cycle.
- Throughput: 1 result/cycle sustained with out_ready held high.
- Reset mid-operation: all buffered entries lost, flags cleared immediately.

## Test plan
- Reset then accept in_sum=0x1234, in_arith=1, no ovfl, out_ready=1 → out_valid next cycle, out_result=0x1234; after commit Z=0,N=0,V=0.
- Accept in_arith=1, in_pos_ovfl=1, in_sum=0x8001 → out_result=0x7FFF; on commit V=1,N=0,Z=0. Then in_neg_ovfl=1, in_sum=0x7FFF → 0x8000, V=1,N=1.
- With V=1,N=1 set, commit in_zupd=1, in_arith=0, in_sum=0x0000 → Z=1, V=1, N=1 held; then in_arith=0,in_zupd=0,in_sum=0 → no flag change.
- out_ready=0, push 3 results (0x0001,0x0002,0x0003) → in_ready=0 after two accepts, third held upstream; release out_ready → results exit in order 1,2,3, one per cycle.
- Count=1 with out_ready=1 and in_valid=1 every cycle for 8 cycles → count stays 1, 8 results in order, no bubbles.
- Two entries buffered (0x0000 arith, 0x0005 arith), assert flush with out_ready=1 → no commit, count=0 next cycle, flags unchanged; assert rst_n=0 mid-stream → out_valid and all flags 0 immediately.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if
// Bundles the upstream result handshake, the downstream EX/MEM handshake,
// the flush strobe and the architectural flag outputs of the result stage.
//   slave  : the result stage itself (takes in_*, flush, out_ready;
//            drives in_ready, out_*, flag_*)
//   master : the surrounding pipeline (the opposite directions)
interface alu_result_stage_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_sum;
    logic             in_pos_ovfl;
    logic             in_neg_ovfl;
    logic             in_arith;
    logic             in_zupd;
    logic [TAG_W-1:0] in_dst;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_result;
    logic [TAG_W-1:0] out_dst;
    logic             flag_z;
    logic             flag_v;
    logic             flag_n;

    modport slave (
        input  in_valid, in_sum, in_pos_ovfl, in_neg_ovfl, in_arith, in_zupd,
               in_dst, flush, out_ready,
        output in_ready, out_valid, out_result, out_dst, flag_z, flag_v, flag_n
    );

    modport master (
        output in_valid, in_sum, in_pos_ovfl, in_neg_ovfl, in_arith, in_zupd,
               in_dst, flush, out_ready,
        input  in_ready, out_valid, out_result, out_dst, flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered result stage behind the 16-bit CLA adder in Execute. Applies
// saturating arithmetic to ADD/SUB results, buffers results in a 2-entry
// valid/ready FIFO toward EX/MEM, and owns the Z/V/N flag register, which
// is updated only when a result commits downstream.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_result_stage_if.slave (upstream in_*, downstream out_*,
//           flush, flag_z/flag_v/flag_n)
module alu_result_stage #(
    parameter int DEPTH = 2,   // fixed at 2; pointers are 1 bit wide
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_stage_if.slave    bus
);

    typedef struct packed {
        logic [15:0]      result;
        logic [TAG_W-1:0] dst;
        logic             arith;
        logic             zupd;
        logic             ovfl;
    } entry_t;

    entry_t     mem [DEPTH];
    entry_t     new_entry;
    entry_t     head;
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       accept;
    logic       commit;
    logic       flag_z;
    logic       flag_v;
    logic       flag_n;

    // Handshakes depend only on the registered count, never on the
    // opposite side's valid/ready, so no combinational path crosses the stage.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);

    // Flush overrides both sides in the cycle it is asserted.
    assign accept = bus.in_valid  & bus.in_ready  & ~bus.flush;
    assign commit = bus.out_valid & bus.out_ready & ~bus.flush;

    // Saturation is applied on the way in so the stored result is already
    // architectural; positive overflow wins if both bits are (illegally) set.
    always_comb begin
        // NOTE: every field gets a default first so no latch is inferred.
        new_entry        = '0;
        new_entry.result = bus.in_sum;
        new_entry.dst    = bus.in_dst;
        new_entry.arith  = bus.in_arith;
        new_entry.zupd   = bus.in_zupd;
        new_entry.ovfl   = bus.in_arith & (bus.in_pos_ovfl | bus.in_neg_ovfl);
        if (bus.in_arith) begin
            if (bus.in_pos_ovfl) begin
                new_entry.result = 16'h7FFF;
            end else if (bus.in_neg_ovfl) begin
                new_entry.result = 16'h8000;
            end
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.out_result = head.result;
    assign bus.out_dst    = head.dst;

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two entries are reset so out_result/out_dst read 0
            // after reset; at this depth the cost is negligible.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (bus.flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // the pre-edge values of the others.
            if (accept) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (commit) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, commit})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Architectural flags follow the committing head entry. An entry with
    // both arith and zupd set behaves as arith.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else if (commit) begin
            if (head.arith) begin
                flag_z <= (head.result == 16'h0000);
                flag_n <= head.result[15];
                flag_v <= head.ovfl;
            end else if (head.zupd) begin
                flag_z <= (head.result == 16'h0000);
            end
        end
    end

    assign bus.flag_z = flag_z;
    assign bus.flag_v = flag_v;
    assign bus.flag_n = flag_n;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage
// Directed and randomized stimulus for alu_result_stage. A negedge monitor
// keeps a queue of expected results (pushed when an accept is observed,
// popped on commit) and a reference flag register, and compares the DUT
// against them every cycle.
module tb_alu_result_stage;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    alu_result_stage_if #(.TAG_W(4)) bus();

    alu_result_stage #(.DEPTH(2), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] result;
        logic [3:0]  dst;
        logic        arith;
        logic        zupd;
        logic        ovfl;
    } exp_t;

    exp_t q[$];
    logic mz, mv, mn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: what an ADD/SUB result becomes after saturation.
    function automatic logic [15:0] ref_result(input logic [15:0] s, input logic p,
                                               input logic n, input logic a);
        if (a && p) return 16'h7FFF;
        if (a && n) return 16'h8000;
        return s;
    endfunction

    // Monitor / scoreboard. Inputs are driven 1 time unit after posedge, so
    // at negedge they show exactly what the next edge will see.
    always @(negedge clk) begin
        exp_t e;
        bit   can_accept;
        if (!rst_n) begin
            q.delete();
            mz = 1'b0; mv = 1'b0; mn = 1'b0;
        end else begin
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
            check("flags_zvn", {29'd0, bus.flag_z, bus.flag_v, bus.flag_n},
                  {29'd0, mz, mv, mn});
            if (q.size() != 0) begin
                check("out_result", {16'd0, bus.out_result}, {16'd0, q[0].result});
                check("out_dst", {28'd0, bus.out_dst}, {28'd0, q[0].dst});
            end
            can_accept = (q.size() < 2);
            if (bus.flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && bus.out_ready) begin
                    e = q.pop_front();
                    if (e.arith) begin
                        mz = (e.result == 16'h0000);
                        mn = e.result[15];
                        mv = e.ovfl;
                    end else if (e.zupd) begin
                        mz = (e.result == 16'h0000);
                    end
                end
                if (bus.in_valid && can_accept) begin
                    e.result = ref_result(bus.in_sum, bus.in_pos_ovfl, bus.in_neg_ovfl, bus.in_arith);
                    e.dst    = bus.in_dst;
                    e.arith  = bus.in_arith;
                    e.zupd   = bus.in_zupd;
                    e.ovfl   = bus.in_arith && (bus.in_pos_ovfl || bus.in_neg_ovfl);
                    q.push_back(e);
                end
            end
        end
    end

    // Sets inputs for the next rising edge.
    task automatic drive(input logic v, input logic [15:0] s, input logic p, input logic n,
                         input logic a, input logic z, input logic [3:0] d,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        bus.in_valid    = v;
        bus.in_sum      = s;
        bus.in_pos_ovfl = p;
        bus.in_neg_ovfl = n;
        bus.in_arith    = a;
        bus.in_zupd     = z;
        bus.in_dst      = d;
        bus.out_ready   = ordy;
        bus.flush       = fl;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, ordy, 1'b0);
    endtask

    task automatic check_flags(input string name, input logic z, input logic v, input logic n);
        check(name, {29'd0, bus.flag_z, bus.flag_v, bus.flag_n}, {29'd0, z, v, n});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic fz, fv, fn;
        logic p, n;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.in_valid = 1'b0; bus.in_sum = 16'h0; bus.in_pos_ovfl = 1'b0;
        bus.in_neg_ovfl = 1'b0; bus.in_arith = 1'b0; bus.in_zupd = 1'b0;
        bus.in_dst = 4'h0; bus.out_ready = 1'b0; bus.flush = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_result", {16'd0, bus.out_result}, 32'd0);
        check("rst_out_dst", {28'd0, bus.out_dst}, 32'd0);
        check_flags("rst_flags", 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;

        // Plain ADD result.
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0);
        idle(1'b1);
        check("first_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("first_out_result", {16'd0, bus.out_result}, 32'h1234);
        idle(1'b1);
        check_flags("flags_1234", 1'b0, 1'b0, 1'b0);

        // Positive then negative saturation.
        drive(1'b1, 16'h8001, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0);
        idle(1'b1);
        check("pos_sat_result", {16'd0, bus.out_result}, 32'h7FFF);
        idle(1'b1);
        check_flags("flags_pos_sat", 1'b0, 1'b1, 1'b0);
        drive(1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0);
        idle(1'b1);
        check("neg_sat_result", {16'd0, bus.out_result}, 32'h8000);
        idle(1'b1);
        check_flags("flags_neg_sat", 1'b0, 1'b1, 1'b1);

        // Z-only update, then a result that touches no flags.
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check_flags("flags_zupd", 1'b1, 1'b1, 1'b1);
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check_flags("flags_no_upd", 1'b1, 1'b1, 1'b1);

        // Backpressure: third push held while full, then in-order drain.
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
        drive(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
        drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 4'h8, 1'b0, 1'b0);
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, 1'b0);
        check("full_hold_head", {16'd0, bus.out_result}, 32'h0001);
        drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Sustained throughput at count=1.
        drive(1'b1, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0, 1'b1, 1'b0, 4'(i), 1'b1, 1'b0);
            check("stream_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush with two entries buffered and out_ready high.
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
        drive(1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0);
        fz = bus.flag_z; fv = bus.flag_v; fn = bus.flag_n;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        check("pre_flush_full", {31'd0, bus.in_ready}, 32'd0);
        idle(1'b1);
        check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_flags("flush_flags_held", fz, fv, fn);
        idle(1'b1);

        // Randomized traffic; positive overflow never paired with negative.
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 5) == 0);
            n = !p && ($urandom_range(0, 5) == 0);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
                  p, n, 1'($urandom), 1'($urandom), 4'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        repeat (4) idle(1'b1);

        // Reset in the middle of traffic with nonzero flags.
        drive(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 4'hC, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check_flags("pre_reset_flags", 1'b0, 1'b1, 1'b1);
        drive(1'b1, 16'h0042, 1'b0, 1'b0, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0);
        drive(1'b1, 16'h0043, 1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_flags("midrst_flags", 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
